// File: rtl/adder_pkg.sv
// Shared constants for the sequential 64-bit adder: slice geometry, controller
// state encodings and the signed-overflow rule.
package adder_pkg;

    localparam int DEF_SLICE_W    = 16;
    localparam int DEF_NUM_SLICES = 4;
    localparam int IDX_W          = $clog2(DEF_NUM_SLICES);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Two's-complement overflow: like-signed operands produced an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder64_seq_ctrl_fa16.sv
// 16-bit ripple full adder used as the single shared datapath slice.
module FullAdder16Bit (
    input  logic        Ci,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] S,
    output logic        Co
);

    logic [16:0] w_sum;

    assign w_sum = {1'b0, A} + {1'b0, B} + {16'b0, Ci};
    assign S     = w_sum[15:0];
    assign Co    = w_sum[16];

endmodule

// File: rtl/adder64_seq_ctrl.sv
// 64-bit A+B+Ci computed over NUM_SLICES cycles through one shared 16-bit slice,
// with the inter-slice carry held in a register and valid/ready on both sides.
module adder64_seq_ctrl
    import adder_pkg::*;
#(
    parameter int SLICE_W    = DEF_SLICE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [SLICE_W*NUM_SLICES-1:0] A,
    input  logic [SLICE_W*NUM_SLICES-1:0] B,
    input  logic                          Ci,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [SLICE_W*NUM_SLICES-1:0] S,
    output logic                          Co,
    output logic                          Ovf,
    output logic                          Busy
);

    localparam int TOTAL_W  = SLICE_W * NUM_SLICES;
    localparam int IDX_BITS = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SLICES - 1);

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_idx;
    logic [TOTAL_W-1:0]    r_a;
    logic [TOTAL_W-1:0]    r_b;
    logic [TOTAL_W-1:0]    r_s;
    logic                  r_carry;
    logic                  r_co;
    logic                  r_ovf;

    logic [SLICE_W-1:0]    w_a_slices [NUM_SLICES];
    logic [SLICE_W-1:0]    w_b_slices [NUM_SLICES];
    logic [SLICE_W-1:0]    w_slice_a;
    logic [SLICE_W-1:0]    w_slice_b;
    logic [SLICE_W-1:0]    w_slice_s;
    logic                  w_slice_co;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice_mux
            assign w_a_slices[gi] = r_a[gi*SLICE_W +: SLICE_W];
            assign w_b_slices[gi] = r_b[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_slice_a = w_a_slices[r_idx];
    assign w_slice_b = w_b_slices[r_idx];

    // Carry into the slice always comes from r_carry, never from this cycle's slice output.
    FullAdder16Bit u_slice (
        .Ci (r_carry),
        .A  (w_slice_a),
        .B  (w_slice_b),
        .S  (w_slice_s),
        .Co (w_slice_co)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Ci;
                        r_s     <= '0;
                        r_idx   <= '0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_s[r_idx*SLICE_W +: SLICE_W] <= w_slice_s;
                    r_carry <= w_slice_co;
                    r_idx   <= r_idx + IDX_BITS'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_co    <= w_slice_co;
                        r_ovf   <= signed_ovf(r_a[TOTAL_W-1], r_b[TOTAL_W-1], w_slice_s[SLICE_W-1]);
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign InReady  = (r_state == ST_IDLE);
    assign OutValid = (r_state == ST_DONE);
    assign Busy     = (r_state != ST_IDLE);
    assign S        = r_s;
    assign Co       = r_co;
    assign Ovf      = r_ovf;

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Scoreboard bench for adder64_seq_ctrl: driver pushes expected results from an
// arithmetic model, a negedge monitor checks every presented result.
module tb_adder64_seq_ctrl;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [63:0] A;
    logic [63:0] B;
    logic        Ci;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] S;
    logic        Co;
    logic        Ovf;
    logic        Busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rnd_en = 0;
    bit   prev_ov = 0;
    exp_t q[$];

    adder64_seq_ctrl dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .Ci       (Ci),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .S        (S),
        .Co       (Co),
        .Ovf      (Ovf),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: unbounded integer arithmetic, then wrap / range-test.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [64:0]        u;
        logic signed [65:0] w;
        logic signed [65:0] maxv;
        logic signed [65:0] minv;
        exp_t e;
        maxv  = 66'sd9223372036854775807;
        minv  = -66'sd9223372036854775808;
        u     = {1'b0, a} + {1'b0, b} + {64'b0, ci};
        w     = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'b0, ci});
        e.s   = u[63:0];
        e.co  = u[64];
        e.ovf = (w > maxv) || (w < minv);
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, output int acc);
        int   n;
        exp_t e;
        n = 0;
        A = a; B = b; Ci = ci; InValid = 1'b1;
        while (!InReady && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!InReady) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=InReady_low required=InReady_high");
            InValid = 1'b0;
            acc = -1;
            return;
        end
        e     = model(a, b, ci);
        e.acc = cyc + 1;
        q.push_back(e);
        acc = e.acc;
        @(posedge Clk); #1;
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    always @(posedge Clk) begin
        #1;
        if (rnd_en) OutReady = 1'($urandom_range(0, 1));
    end

    always @(posedge Clk) begin
        if (!Rst) begin
            assert (!$isunknown(InValid)) else begin
                errors++;
                $display("FAIL invalid_x actual=%b required=known", InValid);
            end
        end
    end

    // Monitor: compare the presented result every cycle it is valid, pop on handshake.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (OutValid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_outvalid actual=1 required=0");
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc - q[0].acc), 64'd4);
                    chk("sum", S, q[0].s);
                    chk("carry_out", 64'(Co), 64'(q[0].co));
                    chk("overflow", 64'(Ovf), 64'(q[0].ovf));
                    chk("inready_in_done", 64'(InReady), 64'd0);
                    chk("busy_in_done", 64'(Busy), 64'd1);
                    if (OutReady) begin
                        $display("txn accepted_cycle=%0d S=%h Co=%b Ovf=%b", q[0].acc, S, Co, Ovf);
                        void'(q.pop_front());
                    end
                end
            end
            prev_ov = OutValid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1;
        int acc2;
        int n;
        logic [63:0] ra;
        logic [63:0] rb;

        Rst = 1'b1; InValid = 1'b0; A = '0; B = '0; Ci = 1'b0; OutReady = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        chk("rst_inready", 64'(InReady), 64'd1);
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_s", S, 64'd0);
        chk("rst_co_ovf", {62'd0, Co, Ovf}, 64'd0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Back-to-back with OutReady tied high: one op per 6 cycles.
        OutReady = 1'b1;
        send(64'd1, 64'd0, 1'b0, acc1);
        send(64'd1, 64'd1, 1'b1, acc2);
        chk("throughput", 64'(acc2 - acc1), 64'd6);
        drain();

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc1);
        send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, acc1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc1);
        send(64'd56, 64'd2, 1'b0, acc1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, acc1);
        drain();

        // Backpressure: result held for 3 cycles while extra InValid pulses arrive.
        OutReady = 1'b0;
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, acc1);
        n = 0;
        while (!OutValid && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("bp_outvalid_seen", 64'(OutValid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1; A = rnd64(); B = rnd64(); Ci = 1'($urandom_range(0, 1));
            chk("bp_inready", 64'(InReady), 64'd0);
            chk("bp_outvalid", 64'(OutValid), 64'd1);
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk); #1;
        chk("bp_consumed", 64'(OutValid), 64'd0);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);
        repeat (8) @(posedge Clk);
        #1;
        chk("bp_pulses_ignored_busy", 64'(Busy), 64'd0);
        chk("bp_pulses_ignored_ready", 64'(InReady), 64'd1);

        // Asynchronous reset with idx==2.
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, acc1);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk("abort_inready", 64'(InReady), 64'd1);
        chk("abort_outvalid", 64'(OutValid), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_s", S, 64'd0);
        chk("abort_co_ovf", {62'd0, Co, Ovf}, 64'd0);
        q.delete();
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        send(64'd56, 64'd2, 1'b0, acc1);
        drain();

        // Randomized operands with random consumer backpressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = rnd64(); rb = rnd64(); end
                1: begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'($urandom_range(0, 3)); end
                2: begin ra = 64'hFFFF_FFFF_FFFF_FFFF ^ (64'd1 << $urandom_range(0, 63)); rb = 64'd1 << $urandom_range(0, 63); end
                default: begin ra = rnd64(); rb = ~ra; end
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), acc1);
        end
        drain();
        rnd_en = 1'b0;
        @(posedge Clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder64_seq_ctrl.md
Name: adder64_seq_ctrl

Overview:
Sequencer that performs a 64-bit add (A + B + Ci) by time-multiplexing one shared FullAdder16Bit slice over four cycles, chaining the carry through a register. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It is the area-reduced alternative to the fully combinational 64-bit adder.

Parameters:
SLICE_W, 16, width of the shared adder slice; must match FullAdder16Bit
NUM_SLICES, 4, number of slice passes; total width = SLICE_W*NUM_SLICES = 64

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-high reset
InValid  input  1  operand set A/B/Ci valid
InReady  output  1  block can accept operands
A  input  64  operand A
B  input  64  operand B
Ci  input  1  carry-in
OutValid  output  1  result S/Co/Ovf valid
OutReady  input  1  consumer accepts result
S  output  64  sum
Co  output  1  carry-out of bit 63
Ovf  output  1  signed overflow: A[63]==B[63] && S[63]!=A[63]
Busy  output  1  high in ADD or DONE

Behaviour:
- Clocking: one clock, Clk. Rst is asynchronous and active-high.
- Reset values: InReady=1, OutValid=0, S=0, Co=0, Ovf=0, Busy=0, state=IDLE, slice index=0, carry register=0.
- States: IDLE, ADD, DONE.
- IDLE:
  - InReady=1.
  - On InValid && InReady at an edge: capture A, B into operand registers, load carry register with Ci, clear S accumulator, set idx=0, go to ADD.
- ADD:
  - InReady=0.
  - Slice inputs are A_reg[idx*16 +: 16], B_reg[idx*16 +: 16], and carry register.
  - At each edge: write slice sum into S[idx*16 +: 16], carry register <= slice Co, idx++.
  - At the edge where idx==NUM_SLICES-1: go to DONE, set Co from slice Co, compute Ovf from final bits.
- DONE:
  - OutValid=1, InReady=0.
  - S/Co/Ovf held stable while OutValid && !OutReady.
  - On OutReady at an edge: OutValid->0, go to IDLE.
  - S/Co/Ovf keep last values in IDLE; they are only meaningful while OutValid is high.
- Latency:
  - OutValid rises exactly NUM_SLICES (4) edges after the accepting edge.
  - Earliest next acceptance is the edge after the OutReady handshake, so throughput is 1 op per 6 cycles with OutReady tied high.
- No overlap: InValid while Busy is ignored. The producer must hold its operands until it sees InReady.
- Wrap-around: the 64-bit sum is modulo 2^64, and the carry out of bit 63 is reported only on Co.
- Inter-slice carry:
  - The carry is taken only from the carry register, never combinationally across cycles.
  - The Ci input is sampled only at the accepting edge.
- Reset mid-operation aborts immediately: all outputs return to reset values, the partial sum is discarded, and InReady=1 after Rst deasserts.
- Operand registers are not cleared by a handshake, only by reset.
- An X on InValid is not tolerated; the bench asserts this.

Decomposition:
- Shared package/header adder_pkg:
  - SLICE_W and NUM_SLICES defaults.
  - State encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2.
  - Index width localparam IDX_W=$clog2(NUM_SLICES).
- Sub-module: one instance of the existing FullAdder16Bit as the shared datapath (ports Ci, A, B, S, Co). No other sub-modules.
- Controller FSM, operand registers, carry register and S accumulator stay in adder64_seq_ctrl.

Test Plan:
- A=1, B=0, Ci=0, OutReady=1 -> OutValid 4 edges after accept; S=1, Co=0, Ovf=0; InReady returns 1 the cycle after the handshake.
- A=64'hFFFF_FFFF_FFFF_FFFF, B=1, Ci=0 -> S=0, Co=1, Ovf=0 (full carry ripple through all 4 slices).
- A=64'h0000_0000_0000_FFFF, B=1, Ci=0 -> S=64'h0000_0000_0001_0000, Co=0 (slice-boundary carry). Also A=1, B=1, Ci=1 -> S=3.
- A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> S=64'h8000_0000_0000_0000, Co=0, Ovf=1. Also A=56, B=2 -> S=58, Ovf=0.
- Backpressure: OutReady=0 for 3 cycles in DONE, new InValid pulses meanwhile -> S/Co/OutValid stable, InReady=0, pulses ignored; result consumed on the first OutReady edge.
- Assert Rst asynchronously while idx=2 -> outputs immediately at reset values. After release, A=56, B=2 -> S=58 with normal 4-cycle latency.
